egress_grant_scheduler: RTL and testbench
=========================================

# egress_grant_scheduler

Grants each switch input port exclusive use of its destination output ports for the duration of one packet transfer. Multicast is all-or-nothing: a packet is granted only when every output in its target mask is free. Fairness comes from a round-robin pointer, with an optional starvation guard. Sits between the four `switch_port` instances and the crossbar/output stage of `switch_4port`, and replaces per-output arbitration.

## Interface
- `NUM_PORTS`, 4, number of input and output ports (fixed at 4 for this revision)
- `AGE_LIMIT`, 15, wait cycles before a requester is marked urgent (used only with the starvation guard)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  4  `req[i]` = input port i holds a packet head and requests a grant
- `target_mask`  in  16  target mask of input i on bits `[4i+3:4i]`, bit j = output j; sampled while `req[i]` is high and i is ungranted
- `done`  in  4  `done[i]` is a one-cycle pulse: input i has sent the last beat of its granted packet
- `gnt`  out  4  `gnt[i]` is a level, high from grant until release
- `out_busy`  out  4  output j is reserved by some granted input
- `err_pulse`  out  1  one-cycle pulse on a protocol error

## Operation
- State per input i: IDLE or GRANTED. Also held:
  - `held_mask[i]`, latched at grant
  - `rr_ptr`, 2 bits
- Eligibility of input i in a cycle:
  - i is IDLE,
  - `req[i]` is high,
  - its mask is nonzero,
  - `(mask & out_busy) == 0`, using the registered `out_busy`.
- At most one new grant per cycle. Scan i = rr_ptr, rr_ptr+1, … mod 4; the first eligible input wins.
- On a win by input w:
  - `gnt[w]` goes 1,
  - `held_mask[w]` is set to the mask,
  - `out_busy` is ORed with the mask,
  - `rr_ptr` is set to (w+1) mod 4.
- `rr_ptr` does not change when there is no grant.
- GRANTED to IDLE happens on `done[i]`:
  - `gnt[i]` goes 0,
  - the `held_mask[i]` bits are cleared from `out_busy`,
  - `held_mask[i]` is cleared.
- Deasserting `req[i]` while GRANTED has no effect; the grant persists until `done[i]`.
- Error cases. Each raises `err_pulse` for 1 cycle and leaves state unchanged otherwise:
  - `done[i]` while input i is IDLE,
  - `req[i]` high with a zero mask (repeats every cycle this persists).
- Invariant: the `held_mask` values of GRANTED inputs are pairwise disjoint, and their OR equals `out_busy`.

## Timing
- Reset values: `gnt`=0, `out_busy`=0, `err_pulse`=0, `rr_ptr`=0, all inputs IDLE, all `held_mask`=0.
- Grant latency: `req` sampled at edge N gives `gnt` high after edge N, i.e. 1 cycle, when the input is eligible.
- Release latency: `done` sampled at edge N drops `gnt` and clears `out_busy` after edge N.
- Outputs freed at edge N become eligible for grants evaluated at edge N+1. The minimum bubble is one cycle: no same-cycle reuse of a released output.
- `done[a]` and a new grant to b at the same edge are both applied. The grant decision uses pre-release `out_busy`.
- Asserting reset mid-transfer drops all grants immediately (asynchronously). Upstream ports must re-request.

## Configuration
- `EGRESS_STARVATION_GUARD_EN` defined:
  - Per-input age counter, 4 bits, saturating. It increments each cycle input i is requesting, IDLE and not granted, and clears on grant or when `req[i]` is low.
  - When age ≥ `AGE_LIMIT`, input i is urgent.
  - While any input is urgent, the lowest-index urgent input u takes precedence. No other input whose mask overlaps `mask[u]` may be granted.
  - u is granted as soon as its outputs are free, regardless of `rr_ptr`.
  - Non-overlapping inputs still arbitrate normally.
- Macro undefined: no age counters; pure round-robin. Under sustained traffic a wide multicast may starve.

## Structure
- Shared `packet_pkg` holds:
  - `NUM_PORTS`,
  - `port_mask_t` (logic [3:0]),
  - `port_idx_t` (logic [1:0]),
  - `AGE_LIMIT` default.
- One sub-module, `rr_pick4`: a combinational rotate-priority picker. Inputs are an eligible vector and `rr_ptr`; outputs are one-hot winner and valid. Everything else lives in `egress_grant_scheduler`.
- SVA bound like the existing `arbiter_sva` checks:
  - `gnt` rises at most one bit per cycle,
  - the mask-disjointness invariant holds,
  - `out_busy` equals the OR of held masks.

## Test plan
- After reset: `req`=4'b0001, mask0=4'b0110 → `gnt`=4'b0001 and `out_busy`=4'b0110 one cycle later. `done[0]` pulse → both return to 0 one cycle after.
- `req`=4'b1111, all masks distinct singletons, `rr_ptr`=0 → grants issued to 0, 1, 2, 3 on consecutive cycles; `out_busy`=4'b1111.
- Input 0 granted mask 4'b0011; input 1 requests 4'b0010; input 2 requests 4'b0100 → input 2 granted next cycle. Input 1 is granted exactly 2 cycles after `done[0]`.
- Multicast: input 3 requests 4'b1111 while input 0 holds 4'b0001 → no grant to 3 until `done[0]`, then `gnt[3]` two cycles later.
- Errors: `done[2]` while IDLE, and `req[1]` with mask 0 → `err_pulse`=1 for one cycle each; `gnt` and `out_busy` unchanged. Reset asserted with 2 grants active → `gnt`=0 and `out_busy`=0 immediately.
- Guard enabled, `AGE_LIMIT`=15: input 0 wants 4'b1111 while inputs 1–3 continuously re-request singletons → input 0 granted within 15 + (longest packet) + 2 cycles. Guard disabled: the same stimulus never grants input 0 in 200 cycles.

Source files
------------

// File: rtl/packet_pkg.sv
`default_nettype none
// ==== packet_pkg : shared port count, mask/index types and state encoding for the egress path (rev 1.0) ====
package packet_pkg;

  localparam int NUM_PORTS         = 4;
  localparam int AGE_LIMIT_DEFAULT = 15;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [1:0]           port_idx_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } port_state_t;

  function automatic port_idx_t onehot_to_idx(input port_mask_t oh);
    port_idx_t idx;
    idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (oh[k]) idx = port_idx_t'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ==== rr_pick4 : combinational rotate-priority picker, first eligible at or after ptr wins (rev 1.0) ====
module rr_pick4
  import packet_pkg::*;
(
  input  port_mask_t elig,
  input  port_idx_t  ptr,
  output port_mask_t win_oh,
  output logic       valid
);

  port_idx_t idx;

  always_comb begin
    win_oh = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + port_idx_t'(k);
      if (!valid && elig[idx]) begin
        win_oh[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/egress_grant_scheduler.sv
`default_nettype none
// ==== egress_grant_scheduler : all-or-nothing multicast output reservation with round-robin fairness (rev 1.0) ====
// Optional starvation guard (per-input age counters) enabled by defining EGRESS_STARVATION_GUARD_EN.
module egress_grant_scheduler
  import packet_pkg::*;
`ifdef EGRESS_STARVATION_GUARD_EN
#(
  parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
)
`endif
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [4*NUM_PORTS-1:0] target_mask,
  input  logic [NUM_PORTS-1:0]   done,
  output logic [NUM_PORTS-1:0]   gnt,
  output logic [NUM_PORTS-1:0]   out_busy,
  output logic                   err_pulse
);

  port_state_t state_q [NUM_PORTS];
  port_state_t state_d [NUM_PORTS];
  port_mask_t  held_q  [NUM_PORTS];
  port_mask_t  held_d  [NUM_PORTS];
  port_mask_t  busy_q, busy_d;
  port_idx_t   rr_ptr_q, rr_ptr_d;
  logic        err_q, err_d;

  port_mask_t  mask [NUM_PORTS];
  port_mask_t  elig;
  port_mask_t  cand;
  port_mask_t  rr_oh;
  logic        rr_valid;
  port_mask_t  win_oh;
  logic        win_valid;
  port_idx_t   win_idx;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask[i] = target_mask[4*i +: 4];
      elig[i] = (state_q[i] == ST_IDLE) && req[i] && (|mask[i]) && !(|(mask[i] & busy_q));
    end
  end

  rr_pick4 u_pick (
    .elig   (cand),
    .ptr    (rr_ptr_q),
    .win_oh (rr_oh),
    .valid  (rr_valid)
  );

`ifdef EGRESS_STARVATION_GUARD_EN
  logic [3:0]  age_q [NUM_PORTS];
  logic [3:0]  age_d [NUM_PORTS];
  port_mask_t  urgent;
  port_mask_t  blocked;
  logic        urg_any;
  port_idx_t   urg_idx;

  // The lowest-index urgent input reserves its whole mask against every overlapping contender.
  always_comb begin
    urgent  = '0;
    blocked = '0;
    urg_any = 1'b0;
    urg_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      urgent[i] = (int'(age_q[i]) >= AGE_LIMIT);
    end
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (urgent[i]) begin
        urg_any = 1'b1;
        urg_idx = port_idx_t'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      blocked[i] = urg_any && (port_idx_t'(i) != urg_idx) && (|(mask[i] & mask[urg_idx]));
    end
  end

  assign cand = elig & ~blocked;

  always_comb begin
    win_oh    = rr_oh;
    win_valid = rr_valid;
    if (urg_any && elig[urg_idx]) begin
      win_oh          = '0;
      win_oh[urg_idx] = 1'b1;
      win_valid       = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && (state_q[i] == ST_IDLE) && !win_oh[i]) begin
        age_d[i] = (age_q[i] == 4'hF) ? age_q[i] : age_q[i] + 4'd1;
      end else begin
        age_d[i] = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign cand = elig;

  always_comb begin
    win_oh    = rr_oh;
    win_valid = rr_valid;
  end
`endif

  assign win_idx = onehot_to_idx(win_oh);

  // Eligibility uses pre-release busy_q, so a freed output is reusable only one edge later.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (done[i]) begin
        if (state_q[i] == ST_GRANTED) begin
          state_d[i] = ST_IDLE;
          held_d[i]  = '0;
          busy_d     = busy_d & ~held_q[i];
        end else begin
          err_d = 1'b1;
        end
      end
      if ((state_q[i] == ST_IDLE) && req[i] && (mask[i] == '0)) begin
        err_d = 1'b1;
      end
    end
    if (win_valid) begin
      state_d[win_idx] = ST_GRANTED;
      held_d[win_idx]  = mask[win_idx];
      busy_d           = busy_d | mask[win_idx];
      rr_ptr_d         = win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= ST_IDLE;
        held_q[i]  <= '0;
      end
      busy_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        held_q[i]  <= held_d[i];
      end
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i] = (state_q[i] == ST_GRANTED);
    end
  end

  assign out_busy  = busy_q;
  assign err_pulse = err_q;

  logic       inv_disjoint;
  logic       inv_or;
  port_mask_t held_or;

  always_comb begin
    inv_disjoint = 1'b1;
    held_or      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      held_or = held_or | held_q[i];
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (|(held_q[i] & held_q[j])) inv_disjoint = 1'b0;
      end
    end
    inv_or = (held_or == busy_q);
  end

  a_gnt_single_rise: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt & ~$past(gnt)));
  a_held_disjoint: assert property (@(posedge clk) disable iff (!rst_n) inv_disjoint);
  a_busy_is_or: assert property (@(posedge clk) disable iff (!rst_n) inv_or);

endmodule
`default_nettype wire

// File: tb/tb_egress_grant_scheduler.sv
`default_nettype none
// ==== tb_egress_grant_scheduler : directed scoreboard bench for egress_grant_scheduler (rev 1.0) ====
module tb_egress_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] target_mask = '0;
  logic [3:0]  dir_done = '0;
  logic [3:0]  stress_done = '0;
  logic [3:0]  done;
  logic [3:0]  gnt;
  logic [3:0]  out_busy;
  logic        err_pulse;
  logic        stress_on = 1'b0;

  localparam int PKT_LEN = 6;

  assign done = dir_done | stress_done;

  always #5 clk = ~clk;

  egress_grant_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .target_mask (target_mask),
    .done        (done),
    .gnt         (gnt),
    .out_busy    (out_busy),
    .err_pulse   (err_pulse)
  );

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] b;
    logic       e;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are presented every cycle; compare every expectation whose cycle is due.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      #0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc <= cyc) begin
          checks++;
          if (sb[k].cyc < cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                     sb[k].name, sb[k].cyc, cyc);
          end else if (gnt !== sb[k].g || out_busy !== sb[k].b || err_pulse !== sb[k].e) begin
            errors++;
            $display("FAIL %s: got gnt=%b busy=%b err=%b, expected gnt=%b busy=%b err=%b",
                     sb[k].name, gnt, out_busy, err_pulse, sb[k].g, sb[k].b, sb[k].e);
          end
          sb.delete(k);
        end
      end
    end
  end

  // Stress traffic for inputs 1..3: hold each grant PKT_LEN cycles, then pulse done.
  int scnt [4];
  initial begin
    for (int i = 0; i < 4; i++) scnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 1; i < 4; i++) begin
        if (stress_on && gnt[i]) begin
          scnt[i] = scnt[i] + 1;
          if (scnt[i] == PKT_LEN) begin
            stress_done[i] = 1'b1;
            scnt[i] = 0;
          end else begin
            stress_done[i] = 1'b0;
          end
        end else begin
          scnt[i] = 0;
          stress_done[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_k(input int k, input logic [3:0] g, input logic [3:0] b,
                          input logic e, input string nm);
    exp_t x;
    x.cyc  = cyc + k;
    x.g    = g;
    x.b    = b;
    x.e    = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic setm(input logic [3:0] m0, input logic [3:0] m1,
                      input logic [3:0] m2, input logic [3:0] m3);
    target_mask = {m3, m2, m1, m0};
  endtask

  task automatic do_reset();
    req = '0;
    dir_done = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "post_reset");
    tick();
  endtask

  int  start_cyc;
  int  gnt_cyc;
  bit  got0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "reset_state");
    tick();

    // Single unicast-pair grant and release
    req = 4'b0001; setm(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    expect_k(1, 4'b0001, 4'b0110, 1'b0, "t1_grant");
    tick();
    req = 4'b0000; dir_done = 4'b0001;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "t1_release");
    tick();
    dir_done = '0;
    tick();

    // Four singletons from rr_ptr=0
    do_reset();
    req = 4'b1111; setm(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    expect_k(1, 4'b0001, 4'b0001, 1'b0, "t2_g0");
    expect_k(2, 4'b0011, 4'b0011, 1'b0, "t2_g1");
    expect_k(3, 4'b0111, 4'b0111, 1'b0, "t2_g2");
    expect_k(4, 4'b1111, 4'b1111, 1'b0, "t2_g3");
    repeat (4) tick();
    req = 4'b0000; dir_done = 4'b1111;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "t2_release");
    tick();
    dir_done = '0;
    tick();

    // Overlap blocks input 1, disjoint input 2 proceeds; input 1 waits one bubble after release
    req = 4'b0001; setm(4'b0011, 4'b0010, 4'b0100, 4'b0000);
    expect_k(1, 4'b0001, 4'b0011, 1'b0, "t3_g0");
    tick();
    req = 4'b0110;
    expect_k(1, 4'b0101, 4'b0111, 1'b0, "t3_g2");
    tick();
    expect_k(1, 4'b0101, 4'b0111, 1'b0, "t3_hold");
    tick();
    dir_done = 4'b0001;
    expect_k(1, 4'b0100, 4'b0100, 1'b0, "t3_release0");
    expect_k(2, 4'b0110, 4'b0110, 1'b0, "t3_late_g1");
    tick();
    dir_done = '0;
    tick();
    req = 4'b0000; dir_done = 4'b0110;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "t3_release");
    tick();
    dir_done = '0;
    tick();

    // Broadcast multicast from input 3 waits for input 0
    req = 4'b0001; setm(4'b0001, 4'b0000, 4'b0000, 4'b1111);
    expect_k(1, 4'b0001, 4'b0001, 1'b0, "t4_g0");
    tick();
    req = 4'b1000;
    expect_k(1, 4'b0001, 4'b0001, 1'b0, "t4_block_a");
    expect_k(2, 4'b0001, 4'b0001, 1'b0, "t4_block_b");
    expect_k(3, 4'b0001, 4'b0001, 1'b0, "t4_block_c");
    repeat (3) tick();
    dir_done = 4'b0001;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "t4_release0");
    expect_k(2, 4'b1000, 4'b1111, 1'b0, "t4_mc_grant");
    tick();
    dir_done = '0;
    tick();
    req = 4'b0000; dir_done = 4'b1000;
    expect_k(1, 4'b0000, 4'b0000, 1'b0, "t4_release3");
    tick();
    dir_done = '0;
    tick();

    // Protocol errors leave grants and reservations untouched
    req = 4'b0001; setm(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_k(1, 4'b0001, 4'b0001, 1'b0, "t5_g0");
    tick();
    req = 4'b0000; dir_done = 4'b0100;
    expect_k(1, 4'b0001, 4'b0001, 1'b1, "err_done_idle");
    tick();
    dir_done = '0; req = 4'b0010;
    expect_k(1, 4'b0001, 4'b0001, 1'b1, "err_zero_mask");
    expect_k(2, 4'b0001, 4'b0001, 1'b1, "err_zero_mask_rep");
    tick();
    tick();
    req = 4'b0000;
    expect_k(1, 4'b0001, 4'b0001, 1'b0, "err_clear");
    tick();
    req = 4'b0010; setm(4'b0001, 4'b0010, 4'b0000, 4'b0000);
    expect_k(1, 4'b0011, 4'b0011, 1'b0, "t5_g1");
    tick();
    req = 4'b0000;
    rst_n = 1'b0;
    #2;
    expect_k(0, 4'b0000, 4'b0000, 1'b0, "async_reset");
    ->mon_ev;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Wide multicast against continuously recycling singletons
    stress_on = 1'b1;
    req = 4'b1110; setm(4'b1111, 4'b0010, 4'b0100, 4'b1000);
    expect_k(1, 4'b0010, 4'b0010, 1'b0, "t6_g1");
    expect_k(2, 4'b0110, 4'b0110, 1'b0, "t6_g2");
    expect_k(3, 4'b1110, 4'b1110, 1'b0, "t6_g3");
    repeat (3) tick();
    req = 4'b1111;
    start_cyc = cyc;
    got0 = 1'b0;
    gnt_cyc = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (gnt[0]) begin
        got0 = 1'b1;
        gnt_cyc = cyc;
        break;
      end
    end
    checks++;
`ifdef EGRESS_STARVATION_GUARD_EN
    if (!got0 || (gnt_cyc - start_cyc) > 15 + PKT_LEN + 2) begin
      errors++;
      $display("FAIL starve_guard: granted=%0d after %0d cycles, required grant within %0d",
               got0, gnt_cyc - start_cyc, 15 + PKT_LEN + 2);
    end
`else
    if (got0) begin
      errors++;
      $display("FAIL starve_rr: input 0 granted after %0d cycles, required no grant in 200",
               gnt_cyc - start_cyc);
    end
`endif
    stress_on = 1'b0;
    req = 4'b0000;
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
